// File: rtl/expand_pkg.sv
`default_nettype none
// ============================================================================
// Module      : expand_pkg
// Description : Shared types and helpers for the fire expand engine: FSM
//               state encoding, accumulator width rule and the ReLU /
//               rescale / saturate step applied at the end of every pixel.
//               EXPAND_SAT_EN selects clamping instead of wrap on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
package expand_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Working width of the finalise step; wide enough for any legal ACC_W + 1.
  localparam int MAX_W = 128;

  // Accumulator width that cannot overflow for TAPS signed products.
  function automatic int acc_width(input int width, input int taps);
    return 2 * width + $clog2(taps);
  endfunction

  // Negative sums go to zero, otherwise shift out the fraction and either
  // clamp to the largest positive WIDTH-bit value or keep the low WIDTH bits.
  function automatic logic [MAX_W-1:0] relu_rescale(
    input logic signed [MAX_W-1:0] s,
    input int                      frac_bits,
    input int                      width
  );
    logic signed [MAX_W-1:0] r;
    logic        [MAX_W-1:0] res;
`ifdef EXPAND_SAT_EN
    logic signed [MAX_W-1:0] lim;
    lim = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
`endif
    r = s >>> frac_bits;
    if (s[MAX_W-1]) begin
      res = '0;
    end
`ifdef EXPAND_SAT_EN
    else if (r > lim) begin
      res = lim;
    end
`endif
    else begin
      res = r & ((MAX_W'(1) << width) - MAX_W'(1));
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/expand_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : expand_mac_lane
// Description : One output channel of the expand engine. Registers the
//               kernel tap, forms the product, accumulates over the window
//               and presents the biased, rescaled, ReLU'd result.
// Revision    : 1.0 - initial release
// ============================================================================
module expand_mac_lane
  import expand_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 14,
  parameter int TAPS      = 144
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               beat,
  input  logic               s1_valid,
  input  logic               p_valid,
  input  logic               p_first,
  input  logic [WIDTH-1:0]   pix_s1,
  input  logic [WIDTH-1:0]   kern,
  input  logic [2*WIDTH-1:0] bias,
  output logic [WIDTH-1:0]   result
);

  localparam int ACC_W = acc_width(WIDTH, TAPS);

  logic signed [WIDTH-1:0]   kern_q, kern_d;
  logic signed [2*WIDTH-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [MAX_W-1:0]   sum;

  // Next values: kernel capture, product stage and accumulate/restart.
  always_comb begin
    kern_d = beat ? $signed(kern) : kern_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    if (s1_valid) begin
      prod_d = (2*WIDTH)'($signed(pix_s1)) * (2*WIDTH)'(kern_q);
    end
    if (p_valid) begin
      acc_d = p_first ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
    end
  end

  // Lane pipeline registers; reset discards any partial accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kern_q <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      kern_q <= kern_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  // Bias add and finalise; sampled by the top only on the last-tap cycle.
  always_comb begin
    sum    = MAX_W'(acc_q) + MAX_W'($signed(bias));
    result = WIDTH'(relu_rescale(sum, FRAC_BITS, WIDTH));
  end

endmodule
`default_nettype wire

// File: rtl/fire_expand_engine.sv
`default_nettype none
// ============================================================================
// Module      : fire_expand_engine
// Description : KxK expand-convolution engine. Streams TAPS taps per output
//               pixel through CHOUT MAC lanes, returns one CHOUT-wide word
//               per pixel. Start/done control, valid/ready on both streams.
//               Build option: EXPAND_SAT_EN (clamp positive overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module fire_expand_engine
  import expand_pkg::*;
#(
  parameter int   WIDTH      = 16,
  parameter int   FRAC_BITS  = 14,
  parameter int   CHIN       = 16,
  parameter int   CHOUT      = 64,
  parameter int   KERNEL_DIM = 3,
  parameter int   WOUT       = 64,
  parameter int   NUM_LAYERS = 2,
  localparam int  TAPS       = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int  PIXELS     = WOUT * WOUT,
  localparam int  LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int  AW         = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LW-1:0]            layer_sel,
  output logic                     busy,
  output logic                     done,
  output logic [LW-1:0]            weight_layer,
  output logic [AW-1:0]            weight_addr,
  input  logic [CHOUT*WIDTH-1:0]   kernels,
  input  logic [CHOUT*2*WIDTH-1:0] bias,
  input  logic                     ifm_valid,
  output logic                     ifm_ready,
  input  logic [WIDTH-1:0]         ifm,
  output logic                     ofm_valid,
  input  logic                     ofm_ready,
  output logic [CHOUT*WIDTH-1:0]   ofm
);

  localparam int            PW       = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS - 1);

  // The pipeline spacing argument for backpressure needs at least 4 taps.
  if (TAPS < 4) begin : g_taps_check
    $error("fire_expand_engine: KERNEL_DIM*KERNEL_DIM*CHIN must be at least 4");
  end

  state_t                 state_q, state_d;
  logic [LW-1:0]          layer_q, layer_d;
  logic [AW-1:0]          tap_cnt_q, tap_cnt_d;
  logic [PW-1:0]          in_pix_q, in_pix_d;
  logic [PW-1:0]          out_pix_q, out_pix_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_first_q, s1_first_d;
  logic                   s1_last_q, s1_last_d;
  logic [WIDTH-1:0]       s1_pix_q, s1_pix_d;
  logic                   p_valid_q, p_valid_d;
  logic                   p_first_q, p_first_d;
  logic                   p_last_q, p_last_d;
  logic                   a_last_q, a_last_d;
  logic                   ofm_valid_q, ofm_valid_d;
  logic [CHOUT*WIDTH-1:0] ofm_q, ofm_d;
  logic [CHOUT*WIDTH-1:0] lane_res;
  logic                   beat;
  logic                   ofm_hs;
  logic                   tap_wrap;

  assign beat         = ifm_valid && ifm_ready;
  assign ofm_hs       = ofm_valid_q && ofm_ready;
  assign tap_wrap     = (tap_cnt_q == TAP_LAST);
  assign weight_layer = layer_q;
  assign weight_addr  = tap_cnt_q;
  assign ofm_valid    = ofm_valid_q;
  assign ofm          = ofm_q;

  // State register and all datapath/control flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      layer_q     <= '0;
      tap_cnt_q   <= '0;
      in_pix_q    <= '0;
      out_pix_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_pix_q    <= '0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      a_last_q    <= 1'b0;
      ofm_valid_q <= 1'b0;
      ofm_q       <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      tap_cnt_q   <= tap_cnt_d;
      in_pix_q    <= in_pix_d;
      out_pix_q   <= out_pix_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_pix_q    <= s1_pix_d;
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      a_last_q    <= a_last_d;
      ofm_valid_q <= ofm_valid_d;
      ofm_q       <= ofm_d;
    end
  end

  // Next-state: run ends after the last tap is in and the last pixel is out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (beat && tap_wrap && (in_pix_q == PIX_LAST)) state_d = DRAIN;
      DRAIN:   if (ofm_hs && (out_pix_q == PIX_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; a pixel's last tap waits while the previous result is held.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    ifm_ready = (state_q == RUN) && !(ofm_valid_q && !ofm_ready && tap_wrap);
  end

  // Layer latch and tap/pixel counters.
  always_comb begin
    layer_d   = layer_q;
    tap_cnt_d = tap_cnt_q;
    in_pix_d  = in_pix_q;
    out_pix_d = out_pix_q;
    if ((state_q == IDLE) && start) begin
      layer_d   = layer_sel;
      tap_cnt_d = '0;
      in_pix_d  = '0;
      out_pix_d = '0;
    end else begin
      if (beat) begin
        tap_cnt_d = tap_wrap ? '0 : tap_cnt_q + 1'b1;
        if (tap_wrap) in_pix_d = in_pix_q + 1'b1;
      end
      if (ofm_hs) out_pix_d = out_pix_q + 1'b1;
    end
  end

  // Pipeline tags and output register; a new result wins over a handshake.
  always_comb begin
    s1_valid_d  = beat;
    s1_first_d  = beat && (tap_cnt_q == '0);
    s1_last_d   = beat && tap_wrap;
    s1_pix_d    = beat ? ifm : s1_pix_q;
    p_valid_d   = s1_valid_q;
    p_first_d   = s1_first_q;
    p_last_d    = s1_last_q;
    a_last_d    = p_valid_q && p_last_q;
    ofm_d       = ofm_q;
    ofm_valid_d = ofm_valid_q;
    if (a_last_q) begin
      ofm_d       = lane_res;
      ofm_valid_d = 1'b1;
    end else if (ofm_hs) begin
      ofm_valid_d = 1'b0;
    end
  end

  for (genvar c = 0; c < CHOUT; c++) begin : g_lane
    expand_mac_lane #(
      .WIDTH     (WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .TAPS      (TAPS)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst),
      .beat     (beat),
      .s1_valid (s1_valid_q),
      .p_valid  (p_valid_q),
      .p_first  (p_first_q),
      .pix_s1   (s1_pix_q),
      .kern     (kernels[c*WIDTH +: WIDTH]),
      .bias     (bias[c*2*WIDTH +: 2*WIDTH]),
      .result   (lane_res[c*WIDTH +: WIDTH])
    );
  end

endmodule
`default_nettype wire
